// File: rtl/leaf_stream_bridge_if.sv
// leaf_stream_bridge_if
//   Groups every per-channel handshake bus of the leaf stream bridge.
//   The bridge connects through the slave modport; the leaf interface
//   plus HLS kernel environment (or a testbench) uses the master modport.
//
//   Leaf interface -> bridge : dout_leaf_interface2user, vld_interface2user,
//                              ack_user2interface (ready back to interface)
//   Bridge -> leaf interface : din_leaf_user2interface, vld_user2interface,
//                              ack_interface2user (ready from interface)
//   Bridge -> kernel inputs  : Input_TDATA, Input_TVALID, Input_TLAST,
//                              Input_TREADY (from kernel)
//   Kernel outputs -> bridge : Output_TDATA, Output_TVALID,
//                              Output_TREADY (to kernel)
//   Channel i of a data bus sits at [i*PAYLOAD_BITS +: PAYLOAD_BITS].
interface leaf_stream_bridge_if #(
  parameter int NUM_IN_PORTS  = 2,
  parameter int NUM_OUT_PORTS = 2,
  parameter int PAYLOAD_BITS  = 32
);
  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  dout_leaf_interface2user;
  logic [NUM_IN_PORTS-1:0]               vld_interface2user;
  logic [NUM_IN_PORTS-1:0]               ack_user2interface;

  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface;
  logic [NUM_OUT_PORTS-1:0]              vld_user2interface;
  logic [NUM_OUT_PORTS-1:0]              ack_interface2user;

  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  Input_TDATA;
  logic [NUM_IN_PORTS-1:0]               Input_TVALID;
  logic [NUM_IN_PORTS-1:0]               Input_TLAST;
  logic [NUM_IN_PORTS-1:0]               Input_TREADY;

  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] Output_TDATA;
  logic [NUM_OUT_PORTS-1:0]              Output_TVALID;
  logic [NUM_OUT_PORTS-1:0]              Output_TREADY;

  modport master (
    output dout_leaf_interface2user, vld_interface2user, ack_interface2user,
    output Input_TREADY, Output_TDATA, Output_TVALID,
    input  ack_user2interface, din_leaf_user2interface, vld_user2interface,
    input  Input_TDATA, Input_TVALID, Input_TLAST, Output_TREADY
  );

  modport slave (
    input  dout_leaf_interface2user, vld_interface2user, ack_interface2user,
    input  Input_TREADY, Output_TDATA, Output_TVALID,
    output ack_user2interface, din_leaf_user2interface, vld_user2interface,
    output Input_TDATA, Input_TVALID, Input_TLAST, Output_TREADY
  );
endinterface

// File: rtl/leaf_stream_bridge.sv
// leaf_stream_bridge
//   Bridges the user side of a BFT leaf interface to the AXI-stream ports
//   of an HLS kernel. Every input and output channel has its own
//   first-word-fall-through FIFO, so interface and kernel back-pressure are
//   decoupled. Kernel input channels get TLAST framing from frame_len.
//
//   Ports:
//     clk        - single rising-edge clock
//     ap_rst_n   - asynchronous active-low reset
//     flush      - synchronous clear of all FIFOs and frame counters
//     frame_len  - words per frame on kernel inputs, 0 disables TLAST
//     bus        - handshake buses (leaf_stream_bridge_if, slave modport)
//     in_level   - occupancy of each input FIFO, CNT_BITS per channel
//     out_level  - occupancy of each output FIFO, CNT_BITS per channel

// leaf_stream_fifo
//   FWFT FIFO with registered count. Ports: wr_* producer side,
//   rd_* consumer side, level = current occupancy.
module leaf_stream_fifo #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 16,
  parameter int CNT_BITS = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                ap_rst_n,
  input  logic                flush,
  input  logic                rst_done,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic                wr_valid,
  output logic                wr_ready,
  output logic [WIDTH-1:0]    rd_data,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [CNT_BITS-1:0] level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [CNT_BITS-1:0] count;
  logic                full;
  logic                push;
  logic                pop;

  // Full comes from the registered count only, so a full FIFO refuses a
  // word even when a pop happens in the same cycle; this keeps ready free
  // of any combinational path from the consumer's ready.
  assign full     = (count == CNT_BITS'(DEPTH));
  assign wr_ready = rst_done & ~full & ~flush;
  assign rd_valid = (count != '0);
  assign push     = wr_valid & wr_ready;
  assign pop      = rd_valid & rd_ready;
  assign rd_data  = mem[rd_ptr];
  assign level    = count;

  // Storage is deliberately left out of reset; only pointers and count
  // decide what is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Flush discards any pop in the same cycle (push is already blocked
  // because ready is low while flush is high).
  always_ff @(posedge clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end
endmodule

module leaf_stream_bridge #(
  parameter int NUM_IN_PORTS  = 2,
  parameter int NUM_OUT_PORTS = 2,
  parameter int PAYLOAD_BITS  = 32,
  parameter int FIFO_DEPTH    = 16,
  parameter int CNT_BITS      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                              clk,
  input  logic                              ap_rst_n,
  input  logic                              flush,
  input  logic [15:0]                       frame_len,
  leaf_stream_bridge_if.slave               bus,
  output logic [NUM_IN_PORTS*CNT_BITS-1:0]  in_level,
  output logic [NUM_OUT_PORTS*CNT_BITS-1:0] out_level
);
  logic rst_done;

  // Holds every ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rst_done <= 1'b0;
    end else begin
      rst_done <= 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_IN_PORTS; i++) begin : g_in
    logic [PAYLOAD_BITS-1:0] rd_data;
    logic                    rd_valid;
    logic                    wr_ready;
    logic [CNT_BITS-1:0]     level;
    logic [15:0]             wcnt;
    logic                    tlast;
    logic                    pop;

    leaf_stream_fifo #(
      .WIDTH    (PAYLOAD_BITS),
      .DEPTH    (FIFO_DEPTH),
      .CNT_BITS (CNT_BITS)
    ) u_fifo (
      .clk      (clk),
      .ap_rst_n (ap_rst_n),
      .flush    (flush),
      .rst_done (rst_done),
      .wr_data  (bus.dout_leaf_interface2user[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .wr_valid (bus.vld_interface2user[i]),
      .wr_ready (wr_ready),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .rd_ready (bus.Input_TREADY[i]),
      .level    (level)
    );

    // An exact match is required, so a mid-frame shrink of frame_len
    // below wcnt suppresses TLAST until wcnt wraps through 65535.
    assign tlast = rd_valid & (frame_len != 16'd0) & (wcnt == frame_len - 16'd1);
    assign pop   = rd_valid & bus.Input_TREADY[i];

    assign bus.ack_user2interface[i]                          = wr_ready;
    assign bus.Input_TDATA[i*PAYLOAD_BITS +: PAYLOAD_BITS]    = rd_data;
    assign bus.Input_TVALID[i]                                = rd_valid;
    assign bus.Input_TLAST[i]                                 = tlast;
    assign in_level[i*CNT_BITS +: CNT_BITS]                   = level;

    always_ff @(posedge clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        wcnt <= '0;
      end else if (flush) begin
        wcnt <= '0;
      end else if (pop) begin
        wcnt <= tlast ? 16'd0 : wcnt + 16'd1;
      end
    end
  end

  for (genvar j = 0; j < NUM_OUT_PORTS; j++) begin : g_out
    logic [PAYLOAD_BITS-1:0] rd_data;
    logic                    rd_valid;
    logic                    wr_ready;
    logic [CNT_BITS-1:0]     level;

    leaf_stream_fifo #(
      .WIDTH    (PAYLOAD_BITS),
      .DEPTH    (FIFO_DEPTH),
      .CNT_BITS (CNT_BITS)
    ) u_fifo (
      .clk      (clk),
      .ap_rst_n (ap_rst_n),
      .flush    (flush),
      .rst_done (rst_done),
      .wr_data  (bus.Output_TDATA[j*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .wr_valid (bus.Output_TVALID[j]),
      .wr_ready (wr_ready),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .rd_ready (bus.ack_interface2user[j]),
      .level    (level)
    );

    assign bus.Output_TREADY[j]                                     = wr_ready;
    assign bus.din_leaf_user2interface[j*PAYLOAD_BITS +: PAYLOAD_BITS] = rd_data;
    assign bus.vld_user2interface[j]                                = rd_valid;
    assign out_level[j*CNT_BITS +: CNT_BITS]                        = level;
  end
endmodule

// File: tb/tb_leaf_stream_bridge.sv
// tb_leaf_stream_bridge
//   Scoreboard bench for leaf_stream_bridge. Stimulus runs at posedge+1,
//   the monitor works at negedge: it compares the DUT against a queue model
//   of every channel, then commits the transfers the model says will happen
//   on the coming edge.
module tb_leaf_stream_bridge;
  localparam int NI    = 2;
  localparam int NO    = 2;
  localparam int PB    = 32;
  localparam int DEPTH = 16;
  localparam int CB    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          ap_rst_n;
  logic          flush;
  logic [15:0]   frame_len;
  logic [NI*CB-1:0] in_level;
  logic [NO*CB-1:0] out_level;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: words accepted but not yet delivered, per channel.
  logic [PB-1:0] in_q  [NI][$];
  logic [PB-1:0] out_q [NO][$];
  int            in_deliv     [NI];
  int            in_push_cnt  [NI];
  int            out_push_cnt [NO];
  bit            rst_done_m;

  int            lvl;
  int            fl;
  bit            exp_rdy;
  bit            exp_vld;
  bit            exp_last;
  bit            pop_in   [NI];
  bit            push_in  [NI];
  bit            pop_out  [NO];
  bit            push_out [NO];
  logic [PB-1:0] push_in_data  [NI];
  logic [PB-1:0] push_out_data [NO];

  leaf_stream_bridge_if #(
    .NUM_IN_PORTS  (NI),
    .NUM_OUT_PORTS (NO),
    .PAYLOAD_BITS  (PB)
  ) bus ();

  leaf_stream_bridge #(
    .NUM_IN_PORTS  (NI),
    .NUM_OUT_PORTS (NO),
    .PAYLOAD_BITS  (PB),
    .FIFO_DEPTH    (DEPTH),
    .CNT_BITS      (CB)
  ) dut (
    .clk       (clk),
    .ap_rst_n  (ap_rst_n),
    .flush     (flush),
    .frame_len (frame_len),
    .bus       (bus.slave),
    .in_level  (in_level),
    .out_level (out_level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [PB-1:0] actual,
                             input logic [PB-1:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: actual 0x%08h required 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  // Offers consecutive words base, base+1, ... on input channel ch until n
  // of them have been taken.
  task automatic pushWords(input int ch, input int n, input logic [PB-1:0] base);
    int start = in_push_cnt[ch];
    int guard = 0;
    bus.vld_interface2user[ch] = 1'b1;
    while ((in_push_cnt[ch] - start) < n && guard < 200) begin
      bus.dout_leaf_interface2user[ch*PB +: PB] = base + PB'(in_push_cnt[ch] - start);
      applyStimulus();
      guard++;
    end
    bus.vld_interface2user[ch] = 1'b0;
  endtask

  task automatic kernelWords(input int ch, input int n, input logic [PB-1:0] base);
    int start = out_push_cnt[ch];
    int guard = 0;
    bus.Output_TVALID[ch] = 1'b1;
    while ((out_push_cnt[ch] - start) < n && guard < 200) begin
      bus.Output_TDATA[ch*PB +: PB] = base + PB'(out_push_cnt[ch] - start);
      applyStimulus();
      guard++;
    end
    bus.Output_TVALID[ch] = 1'b0;
  endtask

  // frame_len changes together with flush release, i.e. on a frame boundary.
  task automatic doFlush(input logic [15:0] new_len);
    flush = 1'b1;
    applyStimulus();
    flush     = 1'b0;
    frame_len = new_len;
  endtask

  always @(negedge clk) begin : monitor
    if (!ap_rst_n) begin
      checkOutput("rst_ack_user2interface", PB'(bus.ack_user2interface), '0);
      checkOutput("rst_Output_TREADY", PB'(bus.Output_TREADY), '0);
      checkOutput("rst_Input_TVALID", PB'(bus.Input_TVALID), '0);
      checkOutput("rst_Input_TLAST", PB'(bus.Input_TLAST), '0);
      checkOutput("rst_vld_user2interface", PB'(bus.vld_user2interface), '0);
      checkOutput("rst_in_level", PB'(in_level), '0);
      checkOutput("rst_out_level", PB'(out_level), '0);
      for (int i = 0; i < NI; i++) begin
        in_q[i].delete();
        in_deliv[i] = 0;
      end
      for (int j = 0; j < NO; j++) out_q[j].delete();
      rst_done_m = 1'b0;
    end else begin
      fl = int'(frame_len);
      for (int i = 0; i < NI; i++) begin
        lvl      = in_q[i].size();
        exp_rdy  = rst_done_m && (lvl < DEPTH) && !flush;
        exp_vld  = (lvl != 0);
        exp_last = 1'b0;
        if (exp_vld && fl != 0) exp_last = ((in_deliv[i] % fl) == (fl - 1));
        checkOutput($sformatf("in%0d_ack", i), PB'(bus.ack_user2interface[i]), PB'(exp_rdy));
        checkOutput($sformatf("in%0d_tvalid", i), PB'(bus.Input_TVALID[i]), PB'(exp_vld));
        checkOutput($sformatf("in%0d_tlast", i), PB'(bus.Input_TLAST[i]), PB'(exp_last));
        checkOutput($sformatf("in%0d_level", i), PB'(in_level[i*CB +: CB]), PB'(lvl));
        pop_in[i] = exp_vld && bus.Input_TREADY[i];
        if (pop_in[i])
          checkOutput($sformatf("in%0d_tdata", i), bus.Input_TDATA[i*PB +: PB], in_q[i][0]);
        push_in[i]      = bus.vld_interface2user[i] && exp_rdy;
        push_in_data[i] = bus.dout_leaf_interface2user[i*PB +: PB];
      end
      for (int j = 0; j < NO; j++) begin
        lvl     = out_q[j].size();
        exp_rdy = rst_done_m && (lvl < DEPTH) && !flush;
        exp_vld = (lvl != 0);
        checkOutput($sformatf("out%0d_tready", j), PB'(bus.Output_TREADY[j]), PB'(exp_rdy));
        checkOutput($sformatf("out%0d_vld", j), PB'(bus.vld_user2interface[j]), PB'(exp_vld));
        checkOutput($sformatf("out%0d_level", j), PB'(out_level[j*CB +: CB]), PB'(lvl));
        pop_out[j] = exp_vld && bus.ack_interface2user[j];
        if (pop_out[j])
          checkOutput($sformatf("out%0d_din", j), bus.din_leaf_user2interface[j*PB +: PB], out_q[j][0]);
        push_out[j]      = bus.Output_TVALID[j] && exp_rdy;
        push_out_data[j] = bus.Output_TDATA[j*PB +: PB];
      end
      if (flush) begin
        for (int i = 0; i < NI; i++) begin
          in_q[i].delete();
          in_deliv[i] = 0;
        end
        for (int j = 0; j < NO; j++) out_q[j].delete();
      end else begin
        for (int i = 0; i < NI; i++) begin
          if (pop_in[i]) begin
            void'(in_q[i].pop_front());
            in_deliv[i]++;
          end
          if (push_in[i]) begin
            in_q[i].push_back(push_in_data[i]);
            in_push_cnt[i]++;
          end
        end
        for (int j = 0; j < NO; j++) begin
          if (pop_out[j]) void'(out_q[j].pop_front());
          if (push_out[j]) begin
            out_q[j].push_back(push_out_data[j]);
            out_push_cnt[j]++;
          end
        end
      end
      rst_done_m = 1'b1;
    end
  end

  initial begin
    for (int i = 0; i < NI; i++) begin
      in_deliv[i]    = 0;
      in_push_cnt[i] = 0;
    end
    for (int j = 0; j < NO; j++) out_push_cnt[j] = 0;
    rst_done_m = 1'b0;
    ap_rst_n   = 1'b1;
    flush      = 1'b0;
    frame_len  = 16'd0;
    bus.dout_leaf_interface2user = '0;
    bus.vld_interface2user       = '0;
    bus.ack_interface2user       = '0;
    bus.Input_TREADY             = '0;
    bus.Output_TDATA             = '0;
    bus.Output_TVALID            = '0;
    #1 ap_rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1 ap_rst_n = 1'b1;
    $display("[TB] reset released");
    applyStimulus();
    applyStimulus();

    $display("[TB] passthrough on input ch0");
    bus.Input_TREADY = 2'b11;
    pushWords(0, 16, 32'h0000_0001);
    repeat (3) applyStimulus();

    $display("[TB] back-pressure on input ch1");
    bus.Input_TREADY[1] = 1'b0;
    pushWords(1, 16, 32'h0000_0100);
    bus.vld_interface2user[1] = 1'b1;
    bus.dout_leaf_interface2user[PB +: PB] = 32'h0000_0110;
    repeat (3) applyStimulus();
    bus.Input_TREADY[1] = 1'b1;
    pushWords(1, 4, 32'h0000_0110);
    repeat (20) applyStimulus();

    $display("[TB] framing with frame_len 4 and 0");
    doFlush(16'd4);
    pushWords(0, 10, 32'h0000_0200);
    repeat (3) applyStimulus();
    doFlush(16'd0);
    pushWords(0, 10, 32'h0000_0300);
    repeat (3) applyStimulus();

    $display("[TB] output path with toggling ack");
    bus.ack_interface2user = 2'b00;
    fork
      kernelWords(1, 8, 32'h0000_0400);
      begin
        for (int k = 0; k < 24; k++) begin
          bus.ack_interface2user[1] = ~k[0];
          applyStimulus();
        end
      end
    join
    bus.ack_interface2user = 2'b11;
    repeat (5) applyStimulus();

    $display("[TB] flush with loaded FIFOs");
    bus.Input_TREADY       = 2'b00;
    bus.ack_interface2user = 2'b00;
    pushWords(0, 5, 32'h0000_0500);
    pushWords(1, 5, 32'h0000_0510);
    kernelWords(0, 5, 32'h0000_0520);
    kernelWords(1, 5, 32'h0000_0530);
    doFlush(16'd4);
    applyStimulus();
    bus.Input_TREADY       = 2'b11;
    bus.ack_interface2user = 2'b11;
    pushWords(0, 8, 32'h0000_0600);
    repeat (3) applyStimulus();

    $display("[TB] randomized traffic");
    doFlush(16'd3);
    for (int c = 0; c < 600; c++) begin
      bus.vld_interface2user       = NI'($urandom);
      bus.dout_leaf_interface2user = {$urandom, $urandom};
      bus.Input_TREADY             = NI'($urandom);
      bus.Output_TVALID            = NO'($urandom);
      bus.Output_TDATA             = {$urandom, $urandom};
      bus.ack_interface2user       = NO'($urandom);
      if ($urandom_range(0, 59) == 0) begin
        doFlush(16'($urandom_range(0, 5)));
      end else begin
        applyStimulus();
      end
    end

    $display("[TB] reset asserted mid-transfer");
    bus.Input_TREADY       = 2'b00;
    bus.ack_interface2user = 2'b00;
    bus.vld_interface2user = 2'b11;
    bus.Output_TVALID      = 2'b11;
    repeat (6) begin
      bus.dout_leaf_interface2user = {$urandom, $urandom};
      bus.Output_TDATA             = {$urandom, $urandom};
      applyStimulus();
    end
    ap_rst_n = 1'b0;
    repeat (2) applyStimulus();
    ap_rst_n = 1'b1;
    bus.vld_interface2user = 2'b00;
    bus.Output_TVALID      = 2'b00;
    applyStimulus();
    pushWords(0, 3, 32'h0000_0700);
    kernelWords(1, 3, 32'h0000_0710);
    bus.Input_TREADY       = 2'b11;
    bus.ack_interface2user = 2'b11;
    repeat (30) applyStimulus();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
